// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path: default coordinate widths
// and the rectangular object-entry record used by the sprite/hit logic.
package vga_pkg;

    localparam int VGA_X_W = 10;
    localparam int VGA_Y_W = 10;

    // One rectangular object at the default display-path widths.
    typedef struct packed {
        logic               en;
        logic [VGA_X_W-1:0] px;
        logic [VGA_Y_W-1:0] py;
        logic [VGA_X_W-1:0] w;
        logic [VGA_Y_W-1:0] h;
    } obj_entry_t;

endpackage

// File: rtl/object_range_cmp.sv
// Registered range check of one pixel coordinate against one rectangle.
// The far edges are formed one bit wider than the coordinate so they never
// wrap; w = 0 or h = 0 therefore produces an empty range.
module object_range_cmp
    import vga_pkg::*;
#(
    parameter int X_W = VGA_X_W,
    parameter int Y_W = VGA_Y_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic [X_W-1:0] px_i,
    input  logic [Y_W-1:0] py_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    input  logic [X_W-1:0] x_pos_i,
    input  logic [Y_W-1:0] y_pos_i,
    output logic           en_o,
    output logic           x_in_o,
    output logic           y_in_o
);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;
    logic         x_in_d, y_in_d;
    logic         en_q, x_in_q, y_in_q;

    // Half-open interval tests on both axes.
    always_comb begin
        x_end  = {1'b0, px_i} + {1'b0, w_i};
        y_end  = {1'b0, py_i} + {1'b0, h_i};
        x_in_d = (x_pos_i >= px_i) && ({1'b0, x_pos_i} < x_end);
        y_in_d = (y_pos_i >= py_i) && ({1'b0, y_pos_i} < y_end);
    end

    // Stage-1 register of the range bits together with the object enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            x_in_q <= 1'b0;
            y_in_q <= 1'b0;
        end else begin
            en_q   <= en_i;
            x_in_q <= x_in_d;
            y_in_q <= y_in_d;
        end
    end

    assign en_o   = en_q;
    assign x_in_o = x_in_q;
    assign y_in_o = y_in_q;

endmodule

// File: rtl/multi_object_detection.sv
// Pipelined pixel-versus-object hit detector with double-buffered object
// registers, lowest-index priority and per-frame player collision flags.
module multi_object_detection
    import vga_pkg::*;
#(
    parameter int N_OBJ = 4,
    parameter int X_W   = VGA_X_W,
    parameter int Y_W   = VGA_Y_W,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [X_W-1:0]   cfg_px,
    input  logic [Y_W-1:0]   cfg_py,
    input  logic [X_W-1:0]   cfg_w,
    input  logic [Y_W-1:0]   cfg_h,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [X_W-1:0]   x_pos,
    input  logic [Y_W-1:0]   y_pos,
    output logic             hit_valid,
    output logic [N_OBJ-1:0] hit_vec,
    output logic             hit_any,
    output logic [IDX_W-1:0] hit_idx,
    output logic [N_OBJ-1:0] coll_frame
);

    typedef struct packed {
        logic           en;
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
    } entry_t;

    // Lowest set bit wins so that object 0 (the player) is drawn on top.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [N_OBJ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    entry_t           cfg_entry;
    logic [N_OBJ-1:0] en_s1, x_in_s1, y_in_s1;
    logic             s1_valid_q;

    assign cfg_entry = '{en: cfg_en, px: cfg_px, py: cfg_py, w: cfg_w, h: cfg_h};

    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
        entry_t shadow_q, shadow_d, active_q, active_d;
        logic   wr_sel;

        // An out-of-range cfg_idx matches no entry, so such writes vanish.
        assign wr_sel = cfg_we && (int'(cfg_idx) == gi);

        // Shadow takes writes; active reloads from shadow (write-through
        // included) on frame_start and feeds the comparator directly.
        always_comb begin
            shadow_d = wr_sel ? cfg_entry : shadow_q;
            active_d = frame_start ? shadow_d : active_q;
        end

        // Double-buffered object storage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end

        object_range_cmp #(.X_W(X_W), .Y_W(Y_W)) u_cmp (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (active_d.en),
            .px_i    (active_d.px),
            .py_i    (active_d.py),
            .w_i     (active_d.w),
            .h_i     (active_d.h),
            .x_pos_i (x_pos),
            .y_pos_i (y_pos),
            .en_o    (en_s1[gi]),
            .x_in_o  (x_in_s1[gi]),
            .y_in_o  (y_in_s1[gi])
        );
    end

    // Stage-1 pixel valid, aligned with the registered range bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_valid_q <= 1'b0;
        else        s1_valid_q <= pix_valid;
    end

    logic [N_OBJ-1:0] hit_vec_d, coll_upd, acc_d, coll_frame_d;
    logic [N_OBJ-1:0] hit_vec_q, acc_q, coll_frame_q;
    logic [IDX_W-1:0] hit_idx_d, hit_idx_q;
    logic             hit_any_d, hit_any_q, hit_valid_q;

    // Stage-2 combine, priority encode and collision roll-over; an update
    // landing on the frame_start cycle is credited to the ending frame.
    always_comb begin
        hit_vec_d = s1_valid_q ? (en_s1 & x_in_s1 & y_in_s1) : '0;
        hit_idx_d = prio_enc(hit_vec_d);
        hit_any_d = |hit_vec_d;
        coll_upd  = '0;
        for (int i = 1; i < N_OBJ; i++) begin
            coll_upd[i] = hit_vec_d[0] & hit_vec_d[i];
        end
        acc_d        = frame_start ? '0 : (acc_q | coll_upd);
        coll_frame_d = frame_start ? (acc_q | coll_upd) : coll_frame_q;
    end

    // Stage-2 output and collision state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid_q  <= 1'b0;
            hit_vec_q    <= '0;
            hit_idx_q    <= '0;
            hit_any_q    <= 1'b0;
            acc_q        <= '0;
            coll_frame_q <= '0;
        end else begin
            hit_valid_q  <= s1_valid_q;
            hit_vec_q    <= hit_vec_d;
            hit_idx_q    <= hit_idx_d;
            hit_any_q    <= hit_any_d;
            acc_q        <= acc_d;
            coll_frame_q <= coll_frame_d;
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit_vec    = hit_vec_q;
    assign hit_idx    = hit_idx_q;
    assign hit_any    = hit_any_q;
    assign coll_frame = coll_frame_q;

endmodule

// File: tb/tb_multi_object_detection.sv
// Bench for multi_object_detection: scoreboard of expected hit results,
// table-driven pixel vectors and hand sequences for multi-cycle corners.
module tb_multi_object_detection;

    localparam int N_OBJ = 4;
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic             cfg_en = 1'b0;
    logic [X_W-1:0]   cfg_px = '0;
    logic [Y_W-1:0]   cfg_py = '0;
    logic [X_W-1:0]   cfg_w = '0;
    logic [Y_W-1:0]   cfg_h = '0;
    logic             frame_start = 1'b0;
    logic             pix_valid = 1'b0;
    logic [X_W-1:0]   x_pos = '0;
    logic [Y_W-1:0]   y_pos = '0;
    logic             hit_valid;
    logic [N_OBJ-1:0] hit_vec;
    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic [N_OBJ-1:0] coll_frame;

    multi_object_detection #(.N_OBJ(N_OBJ), .X_W(X_W), .Y_W(Y_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_px(cfg_px), .cfg_py(cfg_py), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .frame_start(frame_start), .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos),
        .hit_valid(hit_valid), .hit_vec(hit_vec), .hit_any(hit_any), .hit_idx(hit_idx),
        .coll_frame(coll_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_OBJ-1:0] vec;
        logic [IDX_W-1:0] idx;
        logic             any;
        int               x;
        int               y;
    } exp_t;

    typedef struct {
        int               x;
        int               y;
        logic [N_OBJ-1:0] vec;
        logic [IDX_W-1:0] idx;
    } vector_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    // Object model: {en, px, py, w, h} for shadow and active copies.
    int   m_sh[N_OBJ][5];
    int   m_ac[N_OBJ][5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        e.vec = '0;
        e.idx = '0;
        e.x   = x;
        e.y   = y;
        for (int i = 0; i < N_OBJ; i++) begin
            if (m_ac[i][0] != 0 && x >= m_ac[i][1] && x < m_ac[i][1] + m_ac[i][3] &&
                y >= m_ac[i][2] && y < m_ac[i][2] + m_ac[i][4])
                e.vec[i] = 1'b1;
        end
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (e.vec[i]) e.idx = IDX_W'(i);
        end
        e.any = |e.vec;
        return e;
    endfunction

    // One clock of stimulus; the model is updated in hardware order:
    // shadow write, commit on frame_start, then the pixel compare.
    task automatic cycle(input bit we, input int idx, input bit en, input int px, input int py,
                         input int w, input int h, input bit fs, input bit pv, input int x, input int y);
        @(negedge clk);
        cfg_we      = we;
        cfg_idx     = IDX_W'(idx);
        cfg_en      = en;
        cfg_px      = X_W'(px);
        cfg_py      = Y_W'(py);
        cfg_w       = X_W'(w);
        cfg_h       = Y_W'(h);
        frame_start = fs;
        pix_valid   = pv;
        x_pos       = X_W'(x);
        y_pos       = Y_W'(y);
        if (we && idx < N_OBJ) m_sh[idx] = '{int'(en), px, py, w, h};
        if (fs) m_ac = m_sh;
        if (pv) sb_q.push_back(model(x, y));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int idx, input bit en, input int px, input int py, input int w, input int h);
        cycle(1, idx, en, px, py, w, h, 0, 0, 0, 0);
    endtask

    task automatic frame();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, x, y);
    endtask

    // Pixel whose expectation is a fixed constant rather than the model.
    task automatic pix_exp(input int x, input int y, input logic [N_OBJ-1:0] vec, input logic [IDX_W-1:0] idx);
        exp_t e;
        @(negedge clk);
        cfg_we = 1'b0; frame_start = 1'b0; pix_valid = 1'b1;
        x_pos = X_W'(x); y_pos = Y_W'(y);
        e.vec = vec; e.idx = idx; e.any = |vec; e.x = x; e.y = y;
        sb_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_OBJ; i++)
            for (int j = 0; j < 5; j++) begin
                m_sh[i][j] = 0;
                m_ac[i][j] = 0;
            end
    endtask

    // Output monitor: pops one expectation per valid result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hit_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_hit_valid", 32'(hit_valid), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("hit_vec@(%0d,%0d)", e.x, e.y), 32'(hit_vec), 32'(e.vec));
                    check($sformatf("hit_idx@(%0d,%0d)", e.x, e.y), 32'(hit_idx), 32'(e.idx));
                    check($sformatf("hit_any@(%0d,%0d)", e.x, e.y), 32'(hit_any), 32'(e.any));
                end
            end else begin
                check("idle_outputs_zero", 32'({hit_vec, hit_idx, hit_any}), 32'(0));
            end
        end
    end

    vector_t tv[11];

    initial begin
        tv[0]  = '{1023, 0, 4'b0010, 2'd1};
        tv[1]  = '{3,    0, 4'b0000, 2'd0};
        tv[2]  = '{1019, 0, 4'b0000, 2'd0};
        tv[3]  = '{1020, 7, 4'b0010, 2'd1};
        tv[4]  = '{1020, 8, 4'b0000, 2'd0};
        tv[5]  = '{50,  50, 4'b0101, 2'd0};
        tv[6]  = '{46,  46, 4'b0001, 2'd0};
        tv[7]  = '{57,  57, 4'b0100, 2'd2};
        tv[8]  = '{58,  50, 4'b0000, 2'd0};
        tv[9]  = '{54,  54, 4'b0101, 2'd0};
        tv[10] = '{55,  47, 4'b0000, 2'd0};
        model_clear();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_hit_valid", 32'(hit_valid), 32'(0));
        check("rst_hit_vec", 32'(hit_vec), 32'(0));
        check("rst_hit_idx", 32'(hit_idx), 32'(0));
        check("rst_hit_any", 32'(hit_any), 32'(0));
        check("rst_coll_frame", 32'(coll_frame), 32'(0));
        rst_n = 1'b1;
        frame();
        pix_exp(0, 0, 4'b0000, 2'd0);
        pix_exp(12, 21, 4'b0000, 2'd0);

        // Basic hit sweep and latency.
        wr(0, 1, 10, 20, 5, 3);
        frame();
        for (int x = 8; x <= 16; x++)
            pix_exp(x, 21, (x >= 10 && x <= 14) ? 4'b0001 : 4'b0000, 2'd0);
        repeat (4) idle();
        pix(10, 21);
        idle();
        check("latency_t+1", 32'(hit_valid), 32'(0));
        idle();
        check("latency_t+2", 32'(hit_valid), 32'(1));

        // Edge clipping and overlap priority from the vector table.
        wr(0, 1, 45, 45, 10, 10);
        wr(1, 1, 1020, 0, 8, 8);
        wr(2, 1, 48, 48, 10, 10);
        wr(3, 0, 0, 0, 0, 0);
        frame();
        foreach (tv[i]) pix_exp(tv[i].x, tv[i].y, tv[i].vec, tv[i].idx);
        wr(0, 0, 45, 45, 10, 10);
        frame();
        pix_exp(50, 50, 4'b0100, 2'd2);

        // Shadow commit: mid-frame move is invisible until frame_start.
        wr(0, 1, 100, 100, 4, 4);
        frame();
        wr(0, 1, 200, 200, 4, 4);
        pix_exp(101, 101, 4'b0001, 2'd0);
        pix_exp(201, 201, 4'b0000, 2'd0);
        frame();
        pix_exp(201, 201, 4'b0001, 2'd0);
        pix_exp(101, 101, 4'b0000, 2'd0);
        // Write, commit and pixel all in the same cycle.
        cycle(1, 0, 1, 300, 300, 4, 4, 1, 1, 301, 301);
        pix_exp(301, 301, 4'b0001, 2'd0);
        pix_exp(201, 201, 4'b0000, 2'd0);

        // Collision flags between player and object 3.
        wr(0, 1, 100, 100, 10, 10);
        wr(3, 1, 105, 105, 10, 10);
        frame();
        pix_exp(107, 107, 4'b1001, 2'd0);
        pix_exp(101, 101, 4'b0001, 2'd0);
        repeat (3) idle();
        frame();
        idle();
        check("coll_overlap", 32'(coll_frame), 32'(4'b1000));
        pix_exp(101, 101, 4'b0001, 2'd0);
        pix_exp(112, 112, 4'b1000, 2'd3);
        repeat (3) idle();
        check("coll_hold", 32'(coll_frame), 32'(4'b1000));
        frame();
        idle();
        check("coll_clear", 32'(coll_frame), 32'(4'b0000));
        // Overlap whose stage-2 update lands on the frame_start cycle.
        pix_exp(107, 107, 4'b1001, 2'd0);
        frame();
        idle();
        check("coll_boundary", 32'(coll_frame), 32'(4'b1000));

        // Reset mid-frame with pixels in flight.
        pix(107, 107);
        pix(107, 107);
        idle();
        check("pre_reset_hit_valid", 32'(hit_valid), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("reset_hit_valid", 32'(hit_valid), 32'(0));
        check("reset_coll_frame", 32'(coll_frame), 32'(0));
        check("reset_hit_vec", 32'(hit_vec), 32'(0));
        sb_q.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Degenerate sizes never hit; object 3 is a small positive control.
        wr(0, 1, 0, 0, 0, 5);
        wr(1, 1, 0, 0, 5, 0);
        wr(2, 1, 600, 470, 0, 10);
        wr(3, 1, 0, 0, 2, 1);
        frame();
        foreach (tv[i]) begin
            if (i < 8) begin
                for (int x = 0; x < 640; x++)
                    pix(x, (i < 5) ? i : 470 + (i - 5) * 4);
            end
        end
        pix_exp(1, 0, 4'b1000, 2'd3);

        repeat (5) idle();
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_object_detection.md
# multi_object_detection

Parametrised, pipelined pixel-versus-object hit detector for the VGA display path. It holds up to N_OBJ rectangular objects in double-buffered registers and compares each incoming pixel coordinate against all of them in parallel. Per pixel, it reports a hit vector, a priority-resolved object index, and per-frame sticky collision flags between object 0 (player) and every other object. It sits between the VGA timing generator and the pixel colour mux.

## Interface
- N_OBJ, default 4: number of objects, 2..16.
- X_W, default 10: width of x coordinates and object widths.
- Y_W, default 10: width of y coordinates and object heights.
- IDX_W, default 2: width of object indices; must equal clog2(N_OBJ).

- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  write strobe to the shadow entry selected by cfg_idx.
- cfg_idx  in  IDX_W  object being written; out-of-range index means the write is ignored.
- cfg_en  in  1  object enable.
- cfg_px / cfg_py  in  X_W / Y_W  top-left corner of the object.
- cfg_w / cfg_h  in  X_W / Y_W  object width / height in pixels.
- frame_start  in  1  one-cycle pulse in vertical blanking; commits the shadow registers and rolls over the collision flags.
- pix_valid  in  1  x_pos/y_pos valid this cycle (active video).
- x_pos / y_pos  in  X_W / Y_W  current pixel coordinate.
- hit_valid  out  1  pix_valid delayed by 2 cycles.
- hit_vec  out  N_OBJ  bit i set when the pixel lies inside object i.
- hit_any  out  1  OR of hit_vec.
- hit_idx  out  IDX_W  lowest set index in hit_vec; 0 when there is no hit.
- coll_frame  out  N_OBJ  collision flags for the completed frame; bit 0 always 0.

## Operation
- **Inside test.** Object i covers a pixel when all of the following hold:
  - enabled;
  - px ≤ x_pos < px + w;
  - py ≤ y_pos < py + h.
- **Arithmetic.** Sums are computed at X_W+1 / Y_W+1 bits, so the far edge never wraps. An object extending past the coordinate range is clipped naturally. w = 0 or h = 0 never hits.
- **Double buffering.** cfg_we writes the shadow entry only. On frame_start, every active entry is loaded from its shadow. Comparisons always use the active entries, so objects never tear mid-frame.
- **Write coinciding with frame_start.** The new value is written to the shadow and also committed to the active entry that cycle (write-through).
- **Priority.** The lowest index wins, so object 0 is drawn on top.
- **Collision accumulator (internal, N_OBJ bits).** On each stage-2 cycle with hit_valid, for i ≥ 1: acc[i] |= hit_vec[0] & hit_vec[i].
- **On frame_start:**
  - coll_frame ← acc | the same-cycle update;
  - acc ← 0.
  - A stage-2 update in that cycle therefore belongs to the ending frame.
- **Reset values.** All of the following are 0:
  - shadow and active entries (all objects disabled);
  - pipeline registers;
  - acc;
  - hit_valid, hit_vec, hit_any, hit_idx, coll_frame.
- **Reset mid-frame.** In-flight pixels and accumulated collisions are discarded.

## Timing
- **Stage 1 (registered):** per-object compare; x/y range bits are registered together with pix_valid.
- **Stage 2 (registered):**
  - AND of the range bits and enable produces hit_vec;
  - priority encode produces hit_idx;
  - the collision accumulator is updated.
- **Latency:** a pixel presented at cycle t appears on the hit_* outputs at cycle t+2.
- **Throughput:** 1 pixel per cycle, no stalls.
- **hit_vec / hit_idx / hit_any when hit_valid = 0:** forced to 0.
- **Config write latency:** a config write at cycle t reaches the active entry at the next frame_start edge. The earliest pixel using it is the first pix_valid after that edge.
- **coll_frame:** changes only in the cycle after frame_start and holds for the whole frame.
- **frame_start and pix_valid asserted together:** legal. The pixel is compared against the newly committed entries.

## Structure
- Shared package `vga_pkg` holds:
  - the object-entry struct {en, px, py, w, h}, sized by X_W/Y_W;
  - the localparam coordinate widths used across the display path.
- Natural sub-module `object_range_cmp`: one object, registered range check. It is instantiated N_OBJ times in a generate loop.
- The priority encoder is an inline function in the top module.

## Test plan
- **Basic hit.** Reset, object 0 = {en, 10, 20, 5, 3}, frame_start, then sweep x 8..16 at y = 21:
  - hit_vec[0] = 1 exactly for x = 10..14;
  - the first hit appears 2 cycles after x = 10 is presented.
- **Edge wrap.** Object 1 = {en, 1020, 0, 8, 8} with X_W = 10, pixel (1023, 0):
  - the pixel hits;
  - pixel (3, 0) does not hit.
- **Overlap priority.** Objects 0 and 2 overlap at (50, 50):
  - hit_vec = 0101, hit_idx = 0, hit_any = 1;
  - with object 0 disabled: hit_idx = 2.
- **Shadow commit.**
  - Move object 0 mid-frame: hits still follow the old position until frame_start.
  - Write at the frame_start cycle: the new position is used immediately.
- **Collision flags.**
  - A frame where objects 0 and 3 overlap gives coll_frame = 1000 after frame_start.
  - The next frame without overlap gives 0000.
  - Asserting rst_n low mid-frame clears coll_frame and hit_valid immediately.
- **Degenerate size.** w = 0 on an enabled object gives no hit anywhere in a full 640×480 sweep.
